// File: rtl/sc_bitstream_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sc_bitstream_accumulator
// Purpose  : Converts LANES parallel stochastic bitstreams back to binary.
//            Each lane counts its ones over one SC window of SC_LEN enabled
//            cycles. At the window end, marked by sc_count_done, the per-lane
//            counts go into a 2-entry FIFO. The FIFO is drained through a
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock          in   1          rising-edge clock
//   reset          in   1          asynchronous reset, active low
//   enable         in   1          sc_bits valid this cycle (window strobe)
//   sc_bits        in   LANES      one stochastic bit per lane
//   sc_count_done  in   1          last bit cycle of the current window
//   flush          in   1          synchronous abort of window and FIFO
//   out_valid      out  1          FIFO head holds a result
//   out_ready      in   1          consumer takes the head this cycle
//   out_data       out  LANES*W    lane i count at out_data[i*W +: W]
//   fifo_count     out  2          FIFO occupancy, 0..2
//   overrun        out  1          sticky: a finished window was dropped
//   clear_overrun  in   1          clears overrun (a same-cycle set wins)
// ============================================================================
module sc_bitstream_accumulator #(
   parameter  int LANES      = 4,
   parameter  int SC_LEN     = 256,
   parameter  int SC_LEN_LOG = 8,
   localparam int W          = SC_LEN_LOG + 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [LANES-1:0]   sc_bits,
   input  logic               sc_count_done,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*W-1:0] out_data,
   output logic [1:0]         fifo_count,
   output logic               overrun,
   input  logic               clear_overrun
);

   localparam int            DW         = LANES * W;
   localparam logic [1:0]    C_FIFO_MAX = 2'd2;

   // W is sized to hold exactly SC_LEN. It is only correct when the two
   // length parameters agree.
   if (SC_LEN != (1 << SC_LEN_LOG)) begin : g_len_check
      $error("sc_bitstream_accumulator: SC_LEN must equal 2**SC_LEN_LOG");
   end

   // -------------------------------------------------------------------------
   // Window control
   // -------------------------------------------------------------------------
   logic window_end;    // final enabled bit of a window
   logic push_req;      // a completed window result wants to enter the FIFO
   logic fifo_full;
   logic pop;
   logic push;
   logic drop;          // completed result lost to a full, unpopped FIFO

   // Lane counts including this cycle's bit. This is the value that is
   // pushed at the window end, so the final bit is part of the result.
   logic [DW-1:0] win_data;

   assign window_end = enable & sc_count_done;
   // flush takes priority: a window ending in the same cycle is discarded
   // and is not counted as an overrun.
   assign push_req   = window_end & ~flush;

   // -------------------------------------------------------------------------
   // Per-lane accumulators
   // -------------------------------------------------------------------------
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [W-1:0] acc_q;
      logic [W-1:0] acc_d;
      logic [W-1:0] sum;

      // The largest value is SC_LEN-1 plus the final bit, and W bits hold
      // SC_LEN, so this sum never wraps.
      assign sum = acc_q + {{(W-1){1'b0}}, sc_bits[i]};
      assign win_data[i*W +: W] = sum;

      always_comb begin
         acc_d = acc_q;
         if (flush) begin
            acc_d = '0;
         end else if (enable) begin
            // Restart from zero at the window end so the next enabled cycle
            // is bit 0 of the following window with no bubble.
            acc_d = sc_count_done ? '0 : sum;
         end
      end

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            acc_q <= '0;
         end else begin
            acc_q <= acc_d;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Two-entry result FIFO
   // -------------------------------------------------------------------------
   logic [DW-1:0] mem_q [2];
   logic          rd_ptr_q;
   logic          rd_ptr_d;
   logic          wr_ptr_q;
   logic          wr_ptr_d;
   logic [1:0]    count_q;
   logic [1:0]    count_d;
   logic          overrun_q;
   logic          overrun_d;

   assign fifo_full = (count_q == C_FIFO_MAX);
   // out_valid comes straight from the occupancy register, so it never has
   // a combinational path from out_ready.
   assign pop       = out_valid & out_ready;
   // When full, a same-cycle pop frees the head slot. The write pointer
   // then equals the read pointer, so the new entry replaces the entry that
   // is leaving.
   assign push      = push_req & (~fifo_full | pop);
   assign drop      = push_req & fifo_full & ~pop;

   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;

      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         if (push) begin
            wr_ptr_d = ~wr_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end

      // drop is already masked by flush, so flush alone leaves overrun as is.
      if (drop) begin
         overrun_d = 1'b1;
      end else if (clear_overrun) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         overrun_q <= 1'b0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // The storage needs no reset. out_data is masked whenever the FIFO is
   // empty, and reset empties the FIFO at once.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= win_data;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign out_valid  = (count_q != 2'd0);
   assign fifo_count = count_q;
   assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
   assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_bitstream_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sc_bitstream_accumulator
// Purpose  : Self-checking bench for sc_bitstream_accumulator. It uses a
//            table of whole-window vectors, hand-written corner sequences
//            and randomized stimulus. All of it is compared every cycle
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_bitstream_accumulator;

   localparam int LANES      = 4;
   localparam int SC_LEN     = 256;
   localparam int SC_LEN_LOG = 8;
   localparam int W          = SC_LEN_LOG + 1;
   localparam int DW         = LANES * W;

   logic             clock = 1'b0;
   logic             reset;
   logic             enable;
   logic [LANES-1:0] sc_bits;
   logic             sc_count_done;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic [1:0]       fifo_count;
   logic             overrun;
   logic             clear_overrun;

   sc_bitstream_accumulator #(
      .LANES      (LANES),
      .SC_LEN     (SC_LEN),
      .SC_LEN_LOG (SC_LEN_LOG)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .sc_bits       (sc_bits),
      .sc_count_done (sc_count_done),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .fifo_count    (fifo_count),
      .overrun       (overrun),
      .clear_overrun (clear_overrun)
   );

   always #5 clock = ~clock;

   // One window vector. Lane i carries a one at bit k when k < lim and
   // k % stride == 0. exp is the hand-computed count per lane.
   typedef struct packed {
      logic [LANES-1:0][9:0]   lim;
      logic [LANES-1:0][9:0]   stride;
      logic [LANES-1:0][W-1:0] exp;
   } win_t;

   win_t tbl [4];
   win_t w10, w20, w30;

   // Reference model: plain integer counts and a queue of results
   int unsigned   m_cnt [LANES];
   logic [DW-1:0] m_q [$];
   logic          m_ovr;

   int n_vec;
   int n_err;

   function automatic win_t mk(input int l0, input int s0, input int e0,
                               input int l1, input int s1, input int e1,
                               input int l2, input int s2, input int e2,
                               input int l3, input int s3, input int e3);
      win_t r;
      r.lim[0] = 10'(l0); r.stride[0] = 10'(s0); r.exp[0] = W'(e0);
      r.lim[1] = 10'(l1); r.stride[1] = 10'(s1); r.exp[1] = W'(e1);
      r.lim[2] = 10'(l2); r.stride[2] = 10'(s2); r.exp[2] = W'(e2);
      r.lim[3] = 10'(l3); r.stride[3] = 10'(s3); r.exp[3] = W'(e3);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < LANES; i++) m_cnt[i] = 0;
      m_q.delete();
      m_ovr = 1'b0;
   endtask

   task automatic model_edge(input logic en, input logic [LANES-1:0] b,
                             input logic done, input logic fl,
                             input logic rdy, input logic clr);
      logic [DW-1:0] res;
      logic          set_ovr;
      set_ovr = 1'b0;
      if (fl) begin
         for (int i = 0; i < LANES; i++) m_cnt[i] = 0;
         m_q.delete();
      end else begin
         if (rdy && m_q.size() != 0) m_q.delete(0);
         if (en) begin
            for (int i = 0; i < LANES; i++) if (b[i]) m_cnt[i]++;
            if (done) begin
               res = '0;
               for (int i = 0; i < LANES; i++) begin
                  res[i*W +: W] = W'(m_cnt[i]);
                  m_cnt[i] = 0;
               end
               if (m_q.size() < 2) m_q.push_back(res);
               else set_ovr = 1'b1;
            end
         end
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [63:0] e_data;
      e_data = '0;
      if (m_q.size() != 0) e_data = 64'(m_q[0]);
      check("out_valid",  64'(out_valid),  64'(m_q.size() != 0));
      check("fifo_count", 64'(fifo_count), 64'(m_q.size()));
      check("out_data",   64'(out_data),   e_data);
      check("overrun",    64'(overrun),    64'(m_ovr));
   endtask

   // Drive one cycle, let the edge happen, then compare away from the edge.
   task automatic step(input logic en, input logic [LANES-1:0] b,
                       input logic done, input logic fl,
                       input logic rdy, input logic clr);
      enable        = en;
      sc_bits       = b;
      sc_count_done = done;
      flush         = fl;
      out_ready     = rdy;
      clear_overrun = clr;
      @(posedge clock);
      #1;
      model_edge(en, b, done, fl, rdy, clr);
      check_outputs();
   endtask

   // rmode: 0 = never ready, 1 = always ready, 2 = ready only on the last bit.
   task automatic run_window(input win_t r, input int gapped, input int rmode);
      for (int k = 0; k < SC_LEN; k++) begin
         logic [LANES-1:0] b;
         logic             last;
         int               ng;
         last = (k == SC_LEN - 1);
         for (int i = 0; i < LANES; i++)
            b[i] = (k < int'(r.lim[i])) && ((k % int'(r.stride[i])) == 0);
         ng = 0;
         if (gapped != 0 && $urandom_range(0, 3) == 0) ng = int'($urandom_range(1, 3));
         for (int g = 0; g < ng; g++)
            step(1'b0, LANES'($urandom), last, 1'b0, rmode == 1, 1'b0);
         step(1'b1, b, last, 1'b0, (rmode == 1) || (rmode == 2 && last), 1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      model_reset();
      reset         = 1'b0;
      enable        = 1'b0;
      sc_bits       = '0;
      sc_count_done = 1'b0;
      flush         = 1'b0;
      out_ready     = 1'b0;
      clear_overrun = 1'b0;

      tbl[0] = mk(256, 1, 256,  256, 2, 128,   0, 1,   0,  64, 1,  64);
      tbl[1] = mk(256, 4,  64,  100, 1, 100, 255, 1, 255,   1, 1,   1);
      tbl[2] = mk(256, 3,  86,  256, 256, 1,  10, 7,   2, 256, 1, 256);
      tbl[3] = mk(256, 1, 256,  256, 1, 256, 256, 1, 256, 256, 1, 256);
      w10    = mk(10, 1, 10,  0, 1, 0,  0, 1, 0,  0, 1, 0);
      w20    = mk(20, 1, 20,  0, 1, 0,  0, 1, 0,  0, 1, 0);
      w30    = mk(30, 1, 30,  0, 1, 0,  0, 1, 0,  0, 1, 0);

      // Reset state
      #12;
      check_outputs();
      @(posedge clock);
      #1 reset = 1'b1;

      // Table windows, ungapped then gapped: one result, valid for exactly one cycle
      for (int pass = 0; pass < 2; pass++) begin
         for (int t = 0; t < 4; t++) begin
            if (pass == 0 || t < 2) begin
               run_window(tbl[t], pass, 1);
               check("tbl_valid", 64'(out_valid), 64'd1);
               check("tbl_data",  64'(out_data),  64'(tbl[t].exp));
               step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
               check("tbl_valid_once", 64'(out_valid), 64'd0);
            end
         end
      end

      // Backpressure across three windows
      run_window(w10, 0, 0);
      run_window(w20, 0, 0);
      run_window(w30, 0, 0);
      check("bp_count",   64'(fifo_count), 64'd2);
      check("bp_head",    64'(out_data),   64'(w10.exp));
      check("bp_overrun", 64'(overrun),    64'd1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("bp_head2",   64'(out_data),   64'(w20.exp));
      check("bp_count1",  64'(fifo_count), 64'd1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("bp_empty",   64'(out_valid),  64'd0);
      check("bp_ovr_hold", 64'(overrun),   64'd1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("bp_ovr_clr", 64'(overrun),    64'd0);

      // Full FIFO with a pop in the window-end cycle
      run_window(w10, 0, 0);
      run_window(w20, 0, 0);
      run_window(w30, 0, 2);
      check("pp_count",   64'(fifo_count), 64'd2);
      check("pp_overrun", 64'(overrun),    64'd0);
      check("pp_head",    64'(out_data),   64'(w20.exp));
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("pp_head3",   64'(out_data),   64'(w30.exp));
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("pp_empty",   64'(out_valid),  64'd0);

      // Flush at bit 100 with one result queued
      run_window(w10, 0, 0);
      check("fl_pre", 64'(fifo_count), 64'd1);
      for (int k = 0; k < 100; k++) step(1'b1, '1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, '1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("fl_count", 64'(fifo_count), 64'd0);
      check("fl_valid", 64'(out_valid),  64'd0);
      run_window(tbl[3], 0, 1);
      check("fl_data", 64'(out_data), 64'(tbl[3].exp));
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Flush coinciding with a window end on a full FIFO: no overrun
      run_window(w10, 0, 0);
      run_window(w20, 0, 0);
      step(1'b1, '1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("flend_count",   64'(fifo_count), 64'd0);
      check("flend_overrun", 64'(overrun),    64'd0);

      // Asynchronous reset mid-stream with a full FIFO and overrun set
      run_window(w10, 0, 0);
      run_window(w20, 0, 0);
      run_window(w30, 0, 0);
      for (int k = 0; k < 50; k++) step(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("rs_valid",   64'(out_valid),  64'd0);
      check("rs_count",   64'(fifo_count), 64'd0);
      check("rs_data",    64'(out_data),   64'd0);
      check("rs_overrun", 64'(overrun),    64'd0);
      model_reset();
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      run_window(tbl[0], 0, 1);
      check("rs_win_valid", 64'(out_valid), 64'd1);
      check("rs_win_data",  64'(out_data),  64'(tbl[0].exp));
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic against the reference model
      for (int c = 0; c < 4000; c++) begin
         step($urandom_range(0, 3) != 0,
              LANES'($urandom),
              $urandom_range(0, 11) == 0,
              $urandom_range(0, 199) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 29) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
